// File: rtl/shiftadd_muladd_pkg.sv
// Shared definitions for the shift-add multiply-accumulate block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shiftadd_muladd_pkg;

    // Operand width used by the RSA datapath.
    localparam int RSA_WIDTH = 1025;

    // Controller states. The unused code 2'd3 is treated as IDLE by the decoder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shiftadd_muladd_if.sv
// Request/result bundle for shiftadd_muladd: start, A, B, C in; P, busy, done out.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured when the engine is IDLE or DONE.
interface shiftadd_muladd_if #(
    parameter int WIDTH = shiftadd_muladd_pkg::RSA_WIDTH
);
    import shiftadd_muladd_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [WIDTH-1:0]     C;
    logic [2*WIDTH-1:0]   P;
    logic                 busy;
    logic                 done;

    // Requester side.
    modport master (
        output start, A, B, C,
        input  P, busy, done
    );

    // Engine side.
    modport slave (
        input  start, A, B, C,
        output P, busy, done
    );

endinterface

// File: rtl/shiftadd_muladd_step.sv
// One shift-add iteration: optionally add A into the upper accumulator half, then shift right by one.
// Latency: combinational. Ports: acc_hi/a_reg/b0 in; new_hi (sum >> 1) and shift_out (sum LSB) out.
// Backpressure: none.
module shiftadd_muladd_step #(
    parameter int WIDTH = shiftadd_muladd_pkg::RSA_WIDTH
) (
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] a_reg,
    input  logic             b0,
    output logic [WIDTH-1:0] new_hi,
    output logic             shift_out
);
    import shiftadd_muladd_pkg::*;

    // WIDTH+1 bits holds the carry; (sum >> 1) always fits back into WIDTH bits
    // because acc_hi and a_reg are both at most 2^WIDTH-1.
    logic [WIDTH:0] sum;

    assign sum       = {1'b0, acc_hi} + (b0 ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    assign new_hi    = sum[WIDTH:1];
    assign shift_out = sum[0];

endmodule

// File: rtl/shiftadd_muladd.sv
// Sequential unsigned P = A*B + C, one multiplier bit per clock (right-shifting accumulator).
// Latency: WIDTH+1 edges from the accepting edge to done, data-independent. Ports: clk, rst, bus (slave).
// Backpressure: start is ignored while busy; a held start re-launches on every DONE cycle.
module shiftadd_muladd
    import shiftadd_muladd_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    shiftadd_muladd_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               last;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   step_hi;
    logic               step_bit;

    logic [2*WIDTH-1:0] p_reg;
    logic               busy_reg;
    logic               done_reg;

    assign bus.P    = p_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

    shiftadd_muladd_step #(.WIDTH(WIDTH)) u_step (
        .acc_hi    (acc_hi),
        .a_reg     (a_reg),
        .b0        (b_reg[0]),
        .new_hi    (step_hi),
        .shift_out (step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            RUN: begin
                last = (cnt == CW'(WIDTH - 1));
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                // IDLE and the unused encoding both wait for a request.
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    // C is preloaded into the upper half: after WIDTH right shifts it lands
    // in the lower half unscaled, so the final {acc_hi, acc_lo} is A*B + C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            p_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (accept) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            acc_hi   <= bus.C;
            acc_lo   <= '0;
            cnt      <= '0;
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else if (state_q == RUN) begin
            acc_hi <= step_hi;
            acc_lo <= {step_bit, acc_lo[WIDTH-1:1]};
            b_reg  <= b_reg >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                p_reg    <= {step_hi, step_bit, acc_lo[WIDTH-1:1]};
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

endmodule
